// File: rtl/rv_fetch_queue.sv
// rv_fetch_queue: RV32 instruction front-end.
// Issues sequential fetch requests to an instruction memory, buffers in-order
// responses in a DEPTH-entry queue and presents one instruction per cycle to ID.
// Handles branch redirect (flush + drop of in-flight responses) and stops on a
// sentinel instruction word.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   req_valid/req_ready/req_addr   fetch request channel to imem
//   rsp_valid/rsp_data        in-order imem responses (latency >= 1)
//   issue_valid/issue_ready/issue_instr/issue_pc   head instruction to ID
//   br_taken/br_target        redirect strobe and target PC (bits [1:0] ignored)
//   exit                      sentinel reached the head; sticky until reset
//
// Optional feature: define RV_FETCH_STATS_EN to add saturating counters
//   stat_issued, stat_flushes, stat_stalls.
module rv_fetch_queue #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     ILEN      = 32,
  parameter int unsigned     DEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [ILEN-1:0] HALT_WORD = ILEN'(32'hAAAA_AAAA)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            rsp_valid,
  input  logic [ILEN-1:0] rsp_data,
  output logic            issue_valid,
  input  logic            issue_ready,
  output logic [ILEN-1:0] issue_instr,
  output logic [XLEN-1:0] issue_pc,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  output logic            exit
`ifdef RV_FETCH_STATS_EN
  ,
  output logic [31:0]     stat_issued,
  output logic [15:0]     stat_flushes,
  output logic [31:0]     stat_stalls
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = CW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t          state;
  logic [ILEN-1:0] q_instr [DEPTH];
  logic [XLEN-1:0] q_pc    [DEPTH];
  logic [CW-1:0]   rd_ptr;
  logic [CW-1:0]   wr_ptr;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;

  logic            run;
  logic            empty;
  logic            full;
  logic            head_halt;
  logic            redirect;
  logic            req_fire;
  logic            rsp_take;
  logic            push;
  logic            pop;
  logic [CW-1:0]   count;
  logic [SW-1:0]   inflight;
  logic [XLEN-1:0] target;

  // Queue status from the extra-MSB pointers
  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign run       = (state == S_RUN);
  assign head_halt = !empty && (q_instr[rd_ptr[AW-1:0]] == HALT_WORD);
  assign redirect  = run && br_taken;
  assign target    = br_target & ~XLEN'(3);

  // Credit: queued entries plus in-flight requests (stale ones included) never exceed DEPTH
  assign inflight  = SW'(count) + SW'(outstanding);
  assign req_valid = run && !redirect && (inflight < SW'(DEPTH));
  assign req_fire  = req_valid && req_ready;
  assign req_addr  = fetch_pc;

  // Responses without an outstanding request are ignored
  assign rsp_take  = rsp_valid && (outstanding != '0);
  assign push      = rsp_take && run && !redirect && (drop == '0);

  assign issue_valid = run && !empty && !head_halt;
  assign issue_instr = q_instr[rd_ptr[AW-1:0]];
  assign issue_pc    = q_pc[rd_ptr[AW-1:0]];
  assign pop         = issue_valid && issue_ready && !redirect;

  assign exit = (state == S_HALT);

  // Control state, pointers, PCs and queue storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      outstanding <= '0;
      drop        <= '0;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_take);

      case (state)
        S_IDLE:  state <= S_RUN;
        S_RUN:   if (!redirect && head_halt) state <= S_HALT;
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase

      if (redirect) begin
        // Everything still in flight is stale; a response arriving now is discarded here
        rd_ptr   <= wr_ptr;
        fetch_pc <= target;
        resp_pc  <= target;
        drop     <= outstanding - CW'(rsp_take);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (rsp_take && (drop != '0)) drop <= drop - CW'(1);
        if (push) begin
          q_instr[wr_ptr[AW-1:0]] <= rsp_data;
          q_pc[wr_ptr[AW-1:0]]    <= resp_pc;
          wr_ptr                  <= wr_ptr + CW'(1);
          resp_pc                 <= resp_pc + XLEN'(4);
        end
        if (pop) rd_ptr <= rd_ptr + CW'(1);
      end
    end
  end

`ifdef RV_FETCH_STATS_EN
  // Saturating activity counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_issued  <= '0;
      stat_flushes <= '0;
      stat_stalls  <= '0;
    end else begin
      if (pop && (stat_issued != '1))       stat_issued  <= stat_issued + 32'd1;
      if (redirect && (stat_flushes != '1)) stat_flushes <= stat_flushes + 16'd1;
      if (issue_valid && !issue_ready && (stat_stalls != '1))
        stat_stalls <= stat_stalls + 32'd1;
    end
  end
`endif

  // Protocol checks
  a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
    rsp_valid |-> (outstanding != '0));
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    push |-> !full);

endmodule

// File: tb/tb_rv_fetch_queue.sv
// Self-checking bench for rv_fetch_queue: imem model with random latency,
// expected issue stream derived from the PC sequence and redirect rules.
module tb_rv_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] HALT     = 32'hAAAA_AAAA;
  localparam logic [31:0] FAR      = 32'h0BAD_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [31:0] req_addr;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        issue_valid;
  logic        issue_ready = 1'b0;
  logic [31:0] issue_instr;
  logic [31:0] issue_pc;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        fq_exit;
`ifdef RV_FETCH_STATS_EN
  logic [31:0] stat_issued;
  logic [15:0] stat_flushes;
  logic [31:0] stat_stalls;
`endif

  rv_fetch_queue dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_instr(issue_instr), .issue_pc(issue_pc),
    .br_taken(br_taken), .br_target(br_target),
    .exit(fq_exit)
`ifdef RV_FETCH_STATS_EN
    , .stat_issued(stat_issued), .stat_flushes(stat_flushes), .stat_stalls(stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
    int unsigned epoch;
  } req_t;

  typedef struct {
    logic [31:0] tgt;
    logic [31:0] exp_pc;
    int unsigned lat;
  } rvec_t;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  req_t        imem_q[$];
  int unsigned last_due = 0;
  int unsigned epoch = 0;
  int unsigned lat_min = 1, lat_max = 1;
  int unsigned req_pct = 100, iss_pct = 100;
  logic [31:0] halt_addr = FAR;
  logic [31:0] exp_pc, exp_req;
  int          qcount = 0;
  int          phase = 0;
  logic        prev_redirect = 1'b0;
  logic        br_req = 1'b0;
  logic [31:0] br_tgt = '0;
  logic [31:0] issued_pcs[$];
  int unsigned issue_cyc[$];
  int          issued_m = 0, flushes_m = 0, stalls_m = 0;
  int          base;
  bit          got;
  rvec_t       rv[4];
  logic [31:0] sl_exp[8];

  function automatic logic [31:0] mem(input logic [31:0] a);
    logic [31:0] w;
    if (a == halt_addr) return HALT;
    w = (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    if (w == HALT) w = ~w;
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive at negedge, observe/check at negedge+1, advance model
  task automatic step();
    logic rsp_here, redir, exp_rv, exp_iv, head_halt;
    int   occ;
    int unsigned lat, due;
    req_t h, r;
    @(negedge clk);
    rsp_here    = (imem_q.size() > 0) && (imem_q[0].due <= cyc);
    rsp_valid   = rsp_here;
    rsp_data    = rsp_here ? mem(imem_q[0].addr) : $urandom();
    req_ready   = ($urandom_range(99) < req_pct);
    issue_ready = ($urandom_range(99) < iss_pct);
    br_taken    = br_req;
    br_target   = br_tgt;
    #1;
    occ       = int'(imem_q.size()) + qcount;
    exp_rv    = (phase == 1) && !br_req && (occ < int'(DEPTH));
    exp_iv    = (phase == 1) && (qcount > 0) && (mem(exp_pc) != HALT);
    head_halt = (phase == 1) && (qcount > 0) && (mem(exp_pc) == HALT);
    check("req_valid", 32'(req_valid), 32'(exp_rv));
    check("issue_valid", 32'(issue_valid), 32'(exp_iv));
    check("exit", 32'(fq_exit), 32'(phase == 2));
    if (exp_rv && req_valid) check("req_addr", req_addr, exp_req);
    if (exp_iv && issue_valid) begin
      check("issue_pc", issue_pc, exp_pc);
      check("issue_instr", issue_instr, mem(exp_pc));
    end
    if (prev_redirect) check("issue_after_redirect", 32'(issue_valid), 32'd0);

    redir = (phase == 1) && br_req;
    if (rsp_here) begin
      h = imem_q.pop_front();
      if ((phase == 1) && !redir && (h.epoch == epoch)) qcount++;
    end
    if (req_valid && req_ready) begin
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      r.addr = req_addr; r.due = due; r.epoch = epoch;
      imem_q.push_back(r);
    end
    if (issue_valid && issue_ready && !redir && (phase == 1)) begin
      issued_pcs.push_back(issue_pc);
      issue_cyc.push_back(cyc);
    end
    if (exp_iv && !issue_ready) stalls_m++;
    if (redir) begin
      epoch++;
      exp_pc  = br_tgt & ~32'h3;
      exp_req = exp_pc;
      qcount  = 0;
      flushes_m++;
    end else if (phase == 1) begin
      if (exp_rv && req_ready) exp_req = exp_req + 32'd4;
      if (exp_iv && issue_ready) begin
        exp_pc = exp_pc + 32'd4;
        qcount--;
        issued_m++;
      end
      if (head_halt) phase = 2;
    end
    prev_redirect = redir;
    cyc++;
  endtask

  // Asynchronous reset pulse away from clock edges
  task automatic do_reset();
    @(negedge clk);
    #3;
    rst = 1'b1; rsp_valid = 1'b0; br_taken = 1'b0; req_ready = 1'b0; issue_ready = 1'b0;
    #1;
    check("rst_req_valid", 32'(req_valid), 32'd0);
    check("rst_issue_valid", 32'(issue_valid), 32'd0);
    check("rst_exit", 32'(fq_exit), 32'd0);
    check("rst_issue_pc", issue_pc, 32'd0);
    check("rst_issue_instr", issue_instr, 32'd0);
    check("rst_req_addr", req_addr, RESET_PC);
    imem_q.delete();
    qcount = 0; phase = 1; epoch++;
    exp_pc = RESET_PC; exp_req = RESET_PC;
    prev_redirect = 1'b0; br_req = 1'b0;
    issued_m = 0; flushes_m = 0; stalls_m = 0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("idle_req_valid", 32'(req_valid), 32'd0);
    check("idle_issue_valid", 32'(issue_valid), 32'd0);
  endtask

  initial begin
    rv[0] = '{32'h0000_0100, 32'h0000_0100, 2};
    rv[1] = '{32'h0000_0102, 32'h0000_0100, 2};
    rv[2] = '{32'h0000_0203, 32'h0000_0200, 3};
    rv[3] = '{32'hFFFF_FFFA, 32'hFFFF_FFF8, 1};
    for (int i = 0; i < 8; i++) sl_exp[i] = 32'(i * 4);

    // Straight line: latency 1, no backpressure
    lat_min = 1; lat_max = 1; req_pct = 100; iss_pct = 100;
    do_reset();
    base = issued_pcs.size();
    for (int k = 0; k < 20; k++) step();
    if (issued_pcs.size() >= base + 8) begin
      for (int i = 0; i < 8; i++) begin
        check($sformatf("sl_pc_%0d", i), issued_pcs[base + i], sl_exp[i]);
        if (i > 0) check($sformatf("sl_gap_%0d", i),
                         32'(issue_cyc[base + i] - issue_cyc[base + i - 1]), 32'd1);
      end
    end else check("sl_count", 32'(issued_pcs.size() - base), 32'd8);

    // Backpressure: ID stalls for 10 cycles, front-end fills to DEPTH then stops
    iss_pct = 0;
    for (int k = 0; k < 10; k++) step();
    check("bp_req_blocked", 32'(req_valid), 32'd0);
    check("bp_head_valid", 32'(issue_valid), 32'd1);
    iss_pct = 100;
    base = issued_pcs.size();
    for (int k = 0; k < 20; k++) step();
    check("bp_drained", 32'(issued_pcs.size() > base + 10), 32'd1);
    for (int i = base + 1; i < issued_pcs.size(); i++)
      check("bp_seq", issued_pcs[i] - issued_pcs[i - 1], 32'd4);

    // Redirect vectors
    for (int v = 0; v < 4; v++) begin
      lat_min = rv[v].lat; lat_max = rv[v].lat; req_pct = 100; iss_pct = 100;
      for (int k = 0; k < 8; k++) step();
      br_req = 1'b1; br_tgt = rv[v].tgt;
      step();
      br_req = 1'b0;
      base = issued_pcs.size(); got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
        step();
        if (issued_pcs.size() > base) got = 1'b1;
      end
      if (got) check($sformatf("redir_pc_%0d", v), issued_pcs[base], rv[v].exp_pc);
      else check($sformatf("redir_timeout_%0d", v), 32'd0, 32'd1);
    end

    // Async reset mid-stream, restart at RESET_PC
    lat_min = 1; lat_max = 3; iss_pct = 60; req_pct = 80;
    for (int k = 0; k < 25; k++) step();
    do_reset();
    base = issued_pcs.size();
    for (int k = 0; k < 15; k++) step();
    if (issued_pcs.size() > base) check("restart_pc", issued_pcs[base], RESET_PC);
    else check("restart_timeout", 32'd0, 32'd1);

    // Halt on sentinel at 0x0C
    halt_addr = 32'h0000_000C; lat_min = 1; lat_max = 1; req_pct = 100; iss_pct = 100;
    do_reset();
    base = issued_pcs.size();
    for (int k = 0; k < 30; k++) step();
    check("halt_count", 32'(issued_pcs.size() - base), 32'd3);
    for (int i = 0; i < 3 && base + i < issued_pcs.size(); i++)
      check($sformatf("halt_pc_%0d", i), issued_pcs[base + i], 32'(i * 4));
    check("halt_exit", 32'(fq_exit), 32'd1);
    check("halt_req_valid", 32'(req_valid), 32'd0);
    halt_addr = FAR;

`ifdef RV_FETCH_STATS_EN
    // 5 issues, 3 stall cycles, 1 flush
    lat_min = 1; lat_max = 1; req_pct = 100; iss_pct = 100;
    do_reset();
    base = issued_pcs.size();
    for (int k = 0; k < 40 && issued_pcs.size() < base + 5; k++) step();
    iss_pct = 0;
    for (int k = 0; k < 3; k++) step();
    iss_pct = 100; br_req = 1'b1; br_tgt = 32'h40;
    step();
    br_req = 1'b0;
    @(posedge clk);
    #1;
    check("stat_issued", stat_issued, 32'd5);
    check("stat_flushes", 32'(stat_flushes), 32'd1);
    check("stat_stalls", stat_stalls, 32'd3);
`endif

    // Randomized traffic against the reference model
    do_reset();
    lat_min = 1; lat_max = 4; req_pct = 75; iss_pct = 70;
    for (int k = 0; k < 3000; k++) begin
      br_req = ($urandom_range(99) < 3);
      br_tgt = $urandom_range(32'h3FF, 0);
      step();
      if (k % 1000 == 999) begin
        br_req = 1'b0;
`ifdef RV_FETCH_STATS_EN
        @(posedge clk);
        #1;
        check("rand_stat_issued", stat_issued, 32'(issued_m));
        check("rand_stat_flushes", 32'(stat_flushes), 32'(flushes_m));
        check("rand_stat_stalls", stat_stalls, 32'(stalls_m));
`endif
        do_reset();
      end
    end
    br_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
